uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 3-sample majority vote per bit.
// Frame: start(0), width data bits LSB first, optional parity, stop(1).
module uart_rx #(
   parameter int width = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             RX_IN,
   input  logic [5:0]       Prescale,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   output logic [width-1:0] P_DATA,
   output logic             data_valid,
   output logic             par_err,
   output logic             stp_err
);

   localparam int BW = (width > 1) ? $clog2(width) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       sync_q;
   logic             rx_s;
   logic [5:0]       edge_q, edge_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [5:0]       pre_q, pre_d;
   logic             pen_q, pen_d;
   logic             ptyp_q, ptyp_d;
   logic [2:0]       smp_q, smp_d;
   logic [width-1:0] shift_q, shift_d;
   logic             pfail_q, pfail_d;
   logic [width-1:0] pdata_q, pdata_d;
   logic             dv_q, dv_d;
   logic             perr_q, perr_d;
   logic             serr_q, serr_d;

   logic [5:0]       half;
   logic [5:0]       last_cnt;
   logic             bit_end;
   logic             bitv;
   logic             par_exp;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], RX_IN};
      end
   end

   assign rx_s     = sync_q[1];
   assign half     = {1'b0, pre_q[5:1]};
   assign last_cnt = pre_q - 6'd1;
   assign bit_end  = (edge_q == last_cnt);
   assign bitv     = (smp_q[0] & smp_q[1])
                   | (smp_q[0] & smp_q[2])
                   | (smp_q[1] & smp_q[2]);
   // Expected parity bit: even parity, flipped for odd.
   assign par_exp  = (^shift_q) ^ ptyp_q;

   always_comb begin
      state_d = state_q;
      edge_d  = edge_q;
      bit_d   = bit_q;
      pre_d   = pre_q;
      pen_d   = pen_q;
      ptyp_d  = ptyp_q;
      smp_d   = smp_q;
      shift_d = shift_q;
      pfail_d = pfail_q;
      pdata_d = pdata_q;
      dv_d    = 1'b0;
      perr_d  = perr_q;
      serr_d  = serr_q;

      if (state_q != IDLE) begin
         edge_d = bit_end ? 6'd0 : edge_q + 6'd1;
         if (edge_q == half - 6'd1) smp_d[0] = rx_s;
         if (edge_q == half)        smp_d[1] = rx_s;
         if (edge_q == half + 6'd1) smp_d[2] = rx_s;
      end

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               edge_d  = 6'd0;
               bit_d   = '0;
               pre_d   = Prescale;
               pen_d   = PAR_EN;
               ptyp_d  = PAR_TYP;
               pfail_d = 1'b0;
               perr_d  = 1'b0;
               serr_d  = 1'b0;
            end
         end
         START: begin
            if (bit_end) state_d = bitv ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d[bit_q] = bitv;
               if (bit_q == LAST_BIT) begin
                  state_d = pen_q ? PARITY : STOP;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               pfail_d = (bitv != par_exp);
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               perr_d  = pfail_q;
               serr_d  = !bitv;
               if (!pfail_q && bitv) begin
                  pdata_d = shift_q;
                  dv_d    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         edge_q  <= '0;
         bit_q   <= '0;
         pre_q   <= '0;
         pen_q   <= 1'b0;
         ptyp_q  <= 1'b0;
         smp_q   <= '0;
         shift_q <= '0;
         pfail_q <= 1'b0;
         pdata_q <= '0;
         dv_q    <= 1'b0;
         perr_q  <= 1'b0;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         edge_q  <= edge_d;
         bit_q   <= bit_d;
         pre_q   <= pre_d;
         pen_q   <= pen_d;
         ptyp_q  <= ptyp_d;
         smp_q   <= smp_d;
         shift_q <= shift_d;
         pfail_q <= pfail_d;
         pdata_q <= pdata_d;
         dv_q    <= dv_d;
         perr_q  <= perr_d;
         serr_q  <= serr_d;
      end
   end

   assign P_DATA     = pdata_q;
   assign data_valid = dv_q;
   assign par_err    = perr_q;
   assign stp_err    = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and random frames against a frame-level model.
// Model predicts pulse cycle, data and error flags per frame.
module tb_uart_rx;

   localparam int W = 8;

   logic         CLK;
   logic         RST;
   logic         RX_IN;
   logic [5:0]   Prescale;
   logic         PAR_EN;
   logic         PAR_TYP;
   logic [W-1:0] P_DATA;
   logic         data_valid;
   logic         par_err;
   logic         stp_err;

   int           total = 0;
   int           bad = 0;
   int unsigned  cyc = 0;
   int unsigned  busy = 0;
   int unsigned  got_cyc[$];
   int unsigned  exp_cyc[$];
   logic [W-1:0] got_dat[$];
   logic [W-1:0] exp_dat[$];
   logic [W-1:0] exp_pdata = '0;
   logic         exp_perr = 1'b0;
   logic         exp_serr = 1'b0;

   uart_rx #(.width(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .RX_IN     (RX_IN),
      .Prescale  (Prescale),
      .PAR_EN    (PAR_EN),
      .PAR_TYP   (PAR_TYP),
      .P_DATA    (P_DATA),
      .data_valid(data_valid),
      .par_err   (par_err),
      .stp_err   (stp_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (data_valid) begin
         got_cyc.push_back(cyc);
         got_dat.push_back(P_DATA);
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // The receiver sees the line 3 edges late and only leaves STOP
   // one edge after its final decision.
   function automatic int unsigned start_edge(input int unsigned t0);
      return (t0 + 3 > busy + 1) ? t0 + 3 : busy + 1;
   endfunction

   task automatic send_frame(input logic [W-1:0] d, input int p,
                             input bit pen, input bit ptyp,
                             input bit flip, input bit bstop,
                             input int gbit);
      logic        fb[$];
      int unsigned t0;
      int unsigned e0;
      int          n;
      fb.push_back(1'b0);
      for (int i = 0; i < W; i++) fb.push_back(d[i]);
      if (pen) fb.push_back((^d) ^ ptyp ^ flip);
      fb.push_back(!bstop);
      n = fb.size();
      Prescale = 6'(p);
      PAR_EN   = pen;
      PAR_TYP  = ptyp;
      t0   = cyc;
      e0   = start_edge(t0);
      busy = e0 + n * p;
      for (int b = 0; b < n; b++) begin
         for (int c = 0; c < p; c++) begin
            RX_IN = fb[b] ^ (b == gbit + 1 && c == p / 2 + 1);
            if (b == 1 && c == 0) begin
               check("par_err clear at start", {31'd0, par_err}, 0);
               check("stp_err clear at start", {31'd0, stp_err}, 0);
               Prescale = (p == 8) ? 6'd32 : 6'd8;
               PAR_EN   = !pen;
               PAR_TYP  = !ptyp;
            end
            @(posedge CLK);
            #1;
         end
      end
      RX_IN    = 1'b1;
      exp_perr = pen && flip;
      exp_serr = bstop;
      if (!exp_perr && !exp_serr) begin
         exp_cyc.push_back(busy);
         exp_dat.push_back(d);
         exp_pdata = d;
      end
   endtask

   task automatic glitch_start(input int p);
      int unsigned e0;
      Prescale = 6'(p);
      e0       = start_edge(cyc);
      busy     = e0 + p;
      exp_perr = 1'b0;
      exp_serr = 1'b0;
      for (int c = 0; c < p / 4; c++) begin
         RX_IN = 1'b0;
         @(posedge CLK);
         #1;
      end
      RX_IN = 1'b1;
   endtask

   task automatic reset_mid(input logic [W-1:0] d, input int p);
      Prescale = 6'(p);
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      for (int b = 0; b < 6; b++) begin
         for (int c = 0; c < ((b == 5) ? p / 2 : p); c++) begin
            RX_IN = (b == 0) ? 1'b0 : d[b-1];
            @(posedge CLK);
            #1;
         end
      end
      RST = 1'b0;
      #1;
      check("rst P_DATA", {24'd0, P_DATA}, 0);
      check("rst data_valid", {31'd0, data_valid}, 0);
      check("rst par_err", {31'd0, par_err}, 0);
      check("rst stp_err", {31'd0, stp_err}, 0);
      RX_IN = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      RST       = 1'b1;
      exp_pdata = '0;
      exp_perr  = 1'b0;
      exp_serr  = 1'b0;
      busy      = cyc;
   endtask

   task automatic settle(input string tag, input int n);
      repeat (n) @(posedge CLK);
      #1;
      check({tag, " pulses"}, got_cyc.size(), exp_cyc.size());
      for (int i = 0; i < got_cyc.size() && i < exp_cyc.size(); i++) begin
         check({tag, " dv cycle"}, got_cyc[i], exp_cyc[i]);
         check({tag, " dv data"}, {24'd0, got_dat[i]}, {24'd0, exp_dat[i]});
      end
      check({tag, " P_DATA"}, {24'd0, P_DATA}, {24'd0, exp_pdata});
      check({tag, " par_err"}, {31'd0, par_err}, {31'd0, exp_perr});
      check({tag, " stp_err"}, {31'd0, stp_err}, {31'd0, exp_serr});
      check({tag, " dv idle"}, {31'd0, data_valid}, 0);
      got_cyc.delete();
      got_dat.delete();
      exp_cyc.delete();
      exp_dat.delete();
   endtask

   initial begin
      int           p;
      int           g;
      bit           pen;
      bit           ptyp;
      bit           flip;
      bit           bst;
      logic [W-1:0] d;

      RST      = 1'b0;
      RX_IN    = 1'b1;
      Prescale = 6'd8;
      PAR_EN   = 1'b0;
      PAR_TYP  = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("reset P_DATA", {24'd0, P_DATA}, 0);
      check("reset data_valid", {31'd0, data_valid}, 0);
      check("reset par_err", {31'd0, par_err}, 0);
      check("reset stp_err", {31'd0, stp_err}, 0);
      RST = 1'b1;
      repeat (4) @(posedge CLK);
      #1;

      send_frame(8'hA5, 8, 0, 0, 0, 0, -1);
      settle("a5 p8", 6);
      send_frame(8'h3C, 16, 1, 0, 0, 0, -1);
      settle("3c even ok", 6);
      send_frame(8'h3C, 16, 1, 0, 1, 0, -1);
      settle("3c even bad", 6);
      send_frame(8'h01, 32, 1, 1, 0, 1, -1);
      settle("01 bad stop", 6);
      send_frame(8'h5A, 32, 1, 1, 0, 0, -1);
      settle("5a after stop err", 6);
      glitch_start(16);
      settle("start glitch", 24);
      send_frame(8'hC3, 8, 0, 0, 0, 0, 3);
      settle("mid-bit glitch", 6);
      send_frame(8'h55, 8, 0, 0, 0, 0, -1);
      send_frame(8'hAA, 8, 0, 0, 0, 0, -1);
      settle("back to back", 6);
      reset_mid(8'h96, 16);
      settle("rst mid frame", 4);
      send_frame(8'h69, 16, 0, 0, 0, 0, -1);
      settle("after rst", 6);

      for (int k = 0; k < 24; k++) begin
         p    = 8 << $urandom_range(0, 2);
         d    = W'($urandom);
         pen  = 1'($urandom_range(0, 1));
         ptyp = 1'($urandom_range(0, 1));
         flip = pen && ($urandom_range(0, 7) == 0);
         bst  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) == 0) g = int'($urandom_range(0, W - 1));
         else g = -1;
         send_frame(d, p, pen, ptyp, flip, bst, g);
         settle("random", 6);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
